dummy_mu_top: RTL and testbench
===============================

Name: dummy_mu_top

Overview:
- Multi-unit successor of the dummy coprocessor. NUM_UNITS independent iterative units each compute one operation with an operand-programmed latency, so several operations are in flight at once.
- Results complete out of order and are returned through a round-robin output arbiter, tagged for the issuer to reorder.
- Sits in the same slot as the dummy coprocessor and drives the same valid/ready + tag interface. It adds an op select and a per-unit busy status.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NUM_UNITS, 4, number of parallel iterative units (>=1, power of 2 not required).
- MAX_LATENCY, 32, max iteration count, power of 2. LatW = $clog2(MAX_LATENCY) is derived; do not override.
- tag_t, logic, operation tag type.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all in-flight operations
- valid_i  in  1  input operation valid
- ready_o  in/out: out  1  at least one unit free
- op_i  in  2  operation: 0 ADD, 1 SUB (rs1-rs2), 2 XOR, 3 PASS (rs1)
- tag_i  in  tag_t  operation tag
- rs1_i  in  DATA_WIDTH  first operand
- rs2_i  in  DATA_WIDTH  second operand; rs2_i[LatW-1:0] is the latency L
- valid_o  out  1  result valid
- ready_i  in  1  consumer ready
- tag_o  out  tag_t  tag of returned result
- rd_o  out  DATA_WIDTH  result
- busy_o  out  NUM_UNITS  per-unit occupied flag

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - All unit state is cleared: busy, done, counters, result and tag registers are 0.
  - The arbiter pointer resets so unit 0 has highest priority.
  - Resulting outputs: ready_o=1, valid_o=0, rd_o=0, tag_o=0, busy_o=0.
- Per-unit state machine, states IDLE -> RUN -> DONE -> IDLE:
  - IDLE: busy=0.
  - On dispatch: latch result, tag and threshold L, clear the counter, go to RUN.
  - RUN: counter increments each cycle; when counter==L go to DONE. Total accept-to-DONE latency is L+1 cycles, so L=0 reaches DONE the cycle after acceptance.
  - DONE: request the arbiter. On grant with ready_i=1, go to IDLE. Hold result and tag otherwise.
- Arithmetic: result is computed at acceptance, width DATA_WIDTH, wraps modulo 2^DATA_WIDTH with no carry out. Only the low LatW bits of rs2_i set the latency; upper bits are ignored for latency but still used for SUB and XOR.
- Dispatch:
  - ready_o = OR of ~busy over all units, from registered state only. A unit freed this cycle is not reusable until the next cycle.
  - Accept when valid_i && ready_o && !flush_i.
  - The lowest-index IDLE unit receives the operation.
- Output arbitration:
  - Round-robin among DONE units, searching from (last granted + 1) mod NUM_UNITS.
  - valid_o = any unit DONE. tag_o and rd_o come from the granted unit and are 0 when valid_o=0.
  - The pointer advances to the granted index only on a valid_o && ready_i handshake.
  - With ready_i=0, the grant and output stay stable. The arbiter recomputes only after a handshake, so a newly completed unit cannot preempt a presented result.
- Simultaneous events:
  - Dispatch and completion of different units in the same cycle are independent.
  - Multiple units reaching DONE in the same cycle are served in round-robin order, one per handshake cycle.
- Flush:
  - flush_i=1 forces every unit to IDLE and clears counters, results and tags. The arbiter pointer is not reset.
  - Any input presented in the flush cycle is dropped (not accepted, ready_o unaffected that cycle).
  - valid_o stays 0 from the following cycle.
- Reset mid-operation: immediate return to reset values. No result from before reset is ever emitted.
- busy_o[i]=1 in RUN or DONE.

Test Plan:
- Reset then single op: ADD rs1=5, rs2=3 (L=3), tag=1, ready_i=1 -> valid_o high exactly 4 cycles after acceptance with rd_o=8, tag=1; busy_o[0] high for those 4 cycles plus the handshake cycle.
- Fill all units: 4 ops with L=7 back to back -> ready_o low after the 4th acceptance; the 5th valid_i is stalled until the first handshake, then is dispatched to the freed unit.
- Out-of-order completion: op A L=10 tag=0, then op B L=0 tag=1 -> B returned first (rd/tag of B), A later; both exactly once.
- Round-robin fairness: 4 ops of equal L dispatched in one burst with ready_i held low until all are DONE, then ready_i=1 -> results returned in unit order 0,1,2,3. Repeat the burst -> order starts from unit 0 (pointer after 3) and stays stable while ready_i toggles.
- Backpressure: DONE result with ready_i=0 for 5 cycles -> valid_o, rd_o, tag_o constant; SUB rs1=2, rs2=3 returns 0xFFFFFFFF.
- Flush mid-run: 3 ops in RUN, assert flush_i with valid_i=1 -> no valid_o ever for those ops, busy_o=0 next cycle, the flush-cycle input not accepted. Async reset during DONE -> valid_o=0 immediately.

Source files
------------

// File: rtl/dummy_mu_top.sv
// rtl/dummy_mu_top.sv - multi-unit iterative coprocessor with round-robin tagged result return
module dummy_mu_top #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  NUM_UNITS   = 4,
  parameter int  MAX_LATENCY = 32,
  parameter type tag_t       = logic,
  localparam int LatW        = $clog2(MAX_LATENCY)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  tag_t                  tag_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output tag_t                  tag_o,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic [NUM_UNITS-1:0]  busy_o
);

  localparam int IdxW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state [NUM_UNITS];
  logic [LatW-1:0]       r_cnt   [NUM_UNITS];
  logic [LatW-1:0]       r_lat   [NUM_UNITS];
  logic [DATA_WIDTH-1:0] r_res   [NUM_UNITS];
  tag_t                  r_tag   [NUM_UNITS];
  logic [IdxW-1:0]       r_ptr;
  logic                  r_lock;
  logic [IdxW-1:0]       r_lock_idx;

  logic [NUM_UNITS-1:0]  w_done;
  logic                  w_accept;
  logic                  w_hs;
  logic [IdxW-1:0]       w_disp_idx;
  logic [IdxW-1:0]       w_rr_idx;
  logic                  w_rr_found;
  logic [IdxW-1:0]       w_sel;
  logic [DATA_WIDTH-1:0] w_res;

  always_comb begin
    busy_o = '0;
    w_done = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      busy_o[i] = (r_state[i] != S_IDLE);
      w_done[i] = (r_state[i] == S_DONE);
    end
  end

  assign ready_o  = ~(&busy_o);
  assign w_accept = valid_i & ready_o & ~flush_i;

  // Scan downward so the lowest-index idle unit wins.
  always_comb begin
    w_disp_idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (!busy_o[i]) w_disp_idx = IdxW'(i);
    end
  end

  always_comb begin
    case (op_i)
      2'd0:    w_res = rs1_i + rs2_i;
      2'd1:    w_res = rs1_i - rs2_i;
      2'd2:    w_res = rs1_i ^ rs2_i;
      default: w_res = rs1_i;
    endcase
  end

  always_comb begin
    int j;
    j          = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      j = (int'(r_ptr) + k) % NUM_UNITS;
      if (!w_rr_found && w_done[j]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IdxW'(j);
      end
    end
  end

  // A presented-but-stalled result stays granted until its handshake.
  assign w_sel   = r_lock ? r_lock_idx : w_rr_idx;
  assign valid_o = |w_done;
  assign w_hs    = valid_o & ready_i;
  assign rd_o    = valid_o ? r_res[w_sel] : '0;
  assign tag_o   = valid_o ? r_tag[w_sel] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr      <= IdxW'(NUM_UNITS - 1);
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_lat[i]   <= '0;
        r_res[i]   <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      if (w_hs) r_ptr <= w_sel;
      if (flush_i || w_hs) begin
        r_lock <= 1'b0;
      end else if (valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (flush_i) begin
          r_state[i] <= S_IDLE;
          r_cnt[i]   <= '0;
          r_lat[i]   <= '0;
          r_res[i]   <= '0;
          r_tag[i]   <= '0;
        end else begin
          case (r_state[i])
            S_IDLE: begin
              if (w_accept && (w_disp_idx == IdxW'(i))) begin
                r_res[i]   <= w_res;
                r_tag[i]   <= tag_i;
                r_lat[i]   <= rs2_i[LatW-1:0];
                r_cnt[i]   <= '0;
                r_state[i] <= S_RUN;
              end
            end
            S_RUN: begin
              if (r_cnt[i] == r_lat[i]) r_state[i] <= S_DONE;
              else                      r_cnt[i]   <= r_cnt[i] + 1'b1;
            end
            S_DONE: begin
              if (w_hs && (w_sel == IdxW'(i))) r_state[i] <= S_IDLE;
            end
            default: r_state[i] <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dummy_mu_top.sv
// tb/tb_dummy_mu_top.sv - self-checking bench for dummy_mu_top
module tb_dummy_mu_top;

  typedef logic [3:0] tag_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  tag_t        tag_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        ready_o;
  logic        valid_o;
  tag_t        tag_o;
  logic [31:0] rd_o;
  logic [3:0]  busy_o;

  dummy_mu_top #(.DATA_WIDTH(32), .NUM_UNITS(4), .MAX_LATENCY(32), .tag_t(tag_t)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .tag_i(tag_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .valid_o(valid_o),
    .ready_i(ready_i), .tag_o(tag_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    tag_t        tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    tag_t        tag;
    logic [31:0] rd;
  } sb_t;

  sb_t         sb[$];
  tag_t        ret_tags[$];
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          first_hs_cyc = -1;
  int          accept_cyc = 0;
  int          busy_cnt, first_v, lat, vcnt;
  bit          mon_found;
  logic [31:0] exp_drv = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  always @(negedge clk) cyc++;

  // Scoreboard: push on acceptance, match by tag on every handshake.
  always @(posedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        mon_found = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          if (!mon_found && sb[k].tag == tag_o) begin
            mon_found = 1'b1;
            check("sb_rd", rd_o, sb[k].rd);
            sb.delete(k);
          end
        end
        if (!mon_found) begin
          n_checks++;
          $display("FAIL sb_unexpected: got tag %0h with no pending entry", tag_o);
        end
        ret_tags.push_back(tag_o);
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
      end
      if (flush_i) sb.delete();
      else if (valid_i && ready_o) sb.push_back('{tag: tag_i, rd: exp_drv});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input tag_t t, input logic [31:0] e);
    @(negedge clk);
    op_i = op; rs1_i = a; rs2_i = b; tag_i = t; exp_drv = e; valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (ready_o) begin
        accept_cyc = cyc;
        return;
      end
    end
    timeout_fail("send");
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    for (int k = 0; k < max; k++) begin
      if (valid_o) return;
      @(negedge clk);
    end
    timeout_fail("wait_valid");
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (busy_o == 4'h0 && !valid_o) return;
      @(negedge clk);
    end
    timeout_fail("drain");
  endtask

  initial begin
    vecs[0] = '{op: 2'd0, rs1: 32'd5,        rs2: 32'd3,        tag: 4'd1, exp: 32'd8};
    vecs[1] = '{op: 2'd1, rs1: 32'd2,        rs2: 32'd3,        tag: 4'd2, exp: 32'hFFFF_FFFF};
    vecs[2] = '{op: 2'd2, rs1: 32'hF0F0_0000, rs2: 32'h0F0F_0002, tag: 4'd3, exp: 32'hFFFF_0002};
    vecs[3] = '{op: 2'd3, rs1: 32'hDEAD_BEEF, rs2: 32'h0000_001F, tag: 4'd4, exp: 32'hDEAD_BEEF};
    vecs[4] = '{op: 2'd0, rs1: 32'hFFFF_FFFF, rs2: 32'h0000_0021, tag: 4'd5, exp: 32'h0000_0020};
    vecs[5] = '{op: 2'd1, rs1: 32'd0,        rs2: 32'h0000_0100, tag: 4'd6, exp: 32'hFFFF_FF00};

    do_reset();
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_busy", busy_o, 0);

    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].tag, vecs[i].exp);
      idle();
      busy_cnt = 0; first_v = 0;
      lat = int'(vecs[i].rs2[4:0]);
      for (int k = 1; k < 100; k++) begin
        if (busy_o[0]) busy_cnt++;
        if (valid_o && first_v == 0) begin
          first_v = k;
          check("vec_rd", rd_o, vecs[i].exp);
          check("vec_tag", tag_o, vecs[i].tag);
        end
        if (!busy_o[0]) break;
        @(negedge clk);
      end
      check("vec_latency", first_v - 1, lat + 1);
      check("vec_busy_cycles", busy_cnt, lat + 2);
    end

    first_hs_cyc = -1;
    for (int t = 0; t < 4; t++) send(2'd0, 32'(t * 10), 32'd7, tag_t'(t), 32'(t * 10 + 7));
    @(negedge clk);
    valid_i = 1'b0;
    check("fill_ready_low", ready_o, 0);
    check("fill_busy_all", busy_o, 4'hF);
    send(2'd0, 32'd1, 32'd0, 4'd4, 32'd1);
    check("fill_5th_after_hs", accept_cyc, first_hs_cyc + 1);
    idle();
    check("fill_5th_unit0", busy_o[0], 1);
    drain();
    check("fill_sb_empty", sb.size(), 0);

    ret_tags.delete();
    send(2'd0, 32'd100, 32'd10, 4'd5, 32'd110);
    send(2'd2, 32'hAA, 32'h40, 4'd6, 32'hEA);
    idle();
    drain();
    check("ooo_count", ret_tags.size(), 2);
    if (ret_tags.size() == 2) begin
      check("ooo_first", ret_tags[0], 4'd6);
      check("ooo_second", ret_tags[1], 4'd5);
    end

    do_reset();
    for (int b = 0; b < 2; b++) begin
      ret_tags.delete();
      ready_i = 1'b0;
      for (int t = 0; t < 4; t++) send(2'd0, 32'(t), 32'd2, tag_t'(8 + 4 * b + t), 32'(t + 2));
      idle();
      repeat (10) @(negedge clk);
      check("rr_all_done", busy_o, 4'hF);
      check("rr_hold_tag", tag_o, tag_t'(8 + 4 * b));
      vcnt = 0;
      while (busy_o != 4'h0 && vcnt < 100) begin
        ready_i = (b == 0) ? 1'b1 : ~ready_i;
        @(negedge clk);
        vcnt++;
      end
      if (vcnt >= 100) timeout_fail("rr_drain");
      check("rr_count", ret_tags.size(), 4);
      if (ret_tags.size() == 4)
        for (int t = 0; t < 4; t++) check("rr_order", ret_tags[t], tag_t'(8 + 4 * b + t));
    end

    ready_i = 1'b0;
    send(2'd1, 32'd2, 32'd3, 4'd3, 32'hFFFF_FFFF);
    idle();
    wait_valid(50);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {valid_o, tag_o, rd_o}, {1'b1, 4'd3, 32'hFFFF_FFFF});
      @(negedge clk);
    end
    ready_i = 1'b1;
    drain();

    for (int t = 1; t < 4; t++) send(2'd0, 32'(t), 32'd20, tag_t'(t), 32'(t + 20));
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; tag_i = 4'd9; rs2_i = 32'd0;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_busy", busy_o, 0);
    check("flush_ready", ready_o, 1);
    vcnt = 0;
    repeat (40) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    check("flush_no_valid", vcnt, 0);
    check("flush_sb_empty", sb.size(), 0);

    ready_i = 1'b0;
    send(2'd3, 32'h1234, 32'd0, 4'd2, 32'h1234);
    idle();
    wait_valid(20);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_rd", rd_o, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    vcnt = 0;
    repeat (10) begin
      if (valid_o) vcnt++;
      @(negedge clk);
    end
    check("arst_no_valid", vcnt, 0);
    check("end_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
